mem_router: RTL and testbench
=============================

Name: mem_router

Overview:
- Sequencing controller between the instruction/data arbiter's shared memory port and the SoC slaves (rom, ram, tim, spi, clint, uart_rx, uart_tx).
- Decodes each request to one slave, tracks the single outstanding transaction, and accepts a response only from the selected slave.
- Generates error responses for decode misses and slave timeouts.
- Holds a one-entry buffer for a request that arrives while a transaction is still in flight.

Parameters:
- NUM_SLV, 7, number of slave ports.
- TIMEOUT, 1024, cycles from issue without the selected slave's mem_ready before a timeout error; must be at least 2.
- SLV_BASE, array [NUM_SLV] of 32-bit, per-slave base address.
- SLV_MASK, array [NUM_SLV] of 32-bit, per-slave mask; address bits set here are offset bits.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m_in  in  mem_in_type  request from arbiter
- m_out  out  mem_out_type  response to arbiter
- s_in  out  mem_in_type[NUM_SLV]  per-slave request
- s_out  in  mem_out_type[NUM_SLV]  per-slave response
- busy  out  1  transaction outstanding (state not IDLE)
- timeout_evt  out  1  one-cycle pulse when a timeout fires
- overflow  out  1  sticky: a request was dropped

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, buffer empty, sel=0, timer=0, overflow=0.
  - All s_in=init_mem_in and m_out=init_mem_out, held for the whole reset.
- Request source:
  - In IDLE, the source is the buffer if it is valid, otherwise m_in.
  - The source is valid when its mem_valid=1. Requests are single-cycle pulses.
- Decode:
  - Slave k hits when (addr & ~SLV_MASK[k]) == SLV_BASE[k].
  - Lowest index wins on overlap.
- IDLE with a valid source:
  - Hit on k: drive s_in[k] = source with mem_addr = addr - SLV_BASE[k] in the same cycle (combinational issue). All other s_in stay init_mem_in.
  - Also on a hit: sel<=k, timer<=0, state<=BUSY.
  - Miss: no s_in driven, state<=ERR.
- BUSY:
  - s_out[sel].mem_ready=1: m_out=s_out[sel] in that cycle (zero added latency), then state<=IDLE.
  - mem_ready from any other slave is ignored.
  - Otherwise timer increments. If timer==TIMEOUT-1 without ready: state<=ERR and timeout_evt=1 in that cycle.
  - Ready and timeout in the same cycle: ready wins, no error, no timeout_evt.
- ERR:
  - Lasts exactly one cycle and drives m_out with mem_ready=1, mem_error=1, mem_rdata=0. Then state<=IDLE.
  - Miss response latency: 1 cycle.
  - Timeout response latency: TIMEOUT+1 cycles after issue.
  - A late ready from a timed-out slave arrives in IDLE/ERR and is discarded.
- m_out outside the cases above = init_mem_out. The block never asserts two responses in one cycle.
- Buffer (1 entry):
  - m_in.mem_valid while BUSY/ERR: captured if the buffer is empty.
  - In IDLE with the buffer valid, the buffer is issued. A simultaneous m_in.mem_valid is captured into the buffer (refill in the same cycle).
  - m_in.mem_valid while the buffer is full and not draining: the request is dropped and overflow<=1 until reset.
  - A buffered entry is issued in the first IDLE cycle after the response, so back-to-back transactions have a 1-cycle gap.
- Reset mid-transaction: state, buffer and timer are cleared immediately. No response is generated for the aborted request.
- Widths: timer is $clog2(TIMEOUT) bits and never wraps. The address subtraction is 32-bit unsigned.

Decomposition:
- Shared package (configure):
  - SLV_BASE/SLV_MASK constant arrays built from the existing *_base_addr/*_mask_addr.
  - Slave index enum (SLV_ROM..SLV_UART_TX).
  - router_timeout constant.
- Shared package (wires): router_state_t enum {IDLE, BUSY, ERR}; the existing mem_in_type/mem_out_type are reused.
- One sub-module: mem_decode. It is combinational, takes an address and returns hit, index and offset. It is instantiated once for the source.
- All sequencing stays in mem_router.

Test Plan:
- Hit pass-through: read to ram, addr=ram_base+0x10; slave ready after 3 cycles with rdata=0xDEADBEEF.
  -> s_in[ram] addr=0x10 in the request cycle; m_out ready, rdata=0xDEADBEEF, error=0 in the same cycle as the slave's ready.
- Decode miss: request to 0xF000_0000 (unmapped).
  -> no s_in valid; next cycle m_out ready=1, error=1, rdata=0; busy high for 1 cycle.
- Timeout: TIMEOUT=16, request to spi, slave never ready.
  -> timeout_evt at cycle 15, error response at cycle 16; a spi ready injected at cycle 20 is ignored (m_out stays init).
- Stray and simultaneous ready: while BUSY on tim, uart_rx asserts ready.
  -> ignored. Separately, with TIMEOUT=16, tim ready at timer==15.
  -> normal response, no error, no timeout_evt.
- Buffer and overflow: ram request; ram ready after 4 cycles; second request (rom) at cycle 1; third request at cycle 2.
  -> rom issued in the first IDLE cycle after the ram response; third request dropped; overflow=1 and stays 1.
- Reset mid-operation: assert reset in BUSY with the buffer full.
  -> busy=0, overflow=0, all s_in/m_out idle asynchronously; after release, a ram request completes normally.

Source files
------------

// File: rtl/mem_router_pkg.sv
// Shared types and address map for the memory router and its slaves.
// The address map is built from the per-slave base/mask pairs below.
package mem_router_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [3:0]  mem_wstrb;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

    localparam mem_in_type  init_mem_in  = '0;
    localparam mem_out_type init_mem_out = '0;

    typedef enum logic [2:0] {
        SLV_ROM, SLV_RAM, SLV_TIM, SLV_SPI, SLV_CLINT, SLV_UART_RX, SLV_UART_TX
    } slv_idx_e;

    typedef enum logic [1:0] {IDLE, BUSY, ERR} router_state_t;

    localparam int NUM_SLV_C      = 7;
    localparam int router_timeout = 1024;

    localparam logic [31:0] rom_base_addr     = 32'h0000_0000;
    localparam logic [31:0] rom_mask_addr     = 32'h0000_FFFF;
    localparam logic [31:0] ram_base_addr     = 32'h1000_0000;
    localparam logic [31:0] ram_mask_addr     = 32'h000F_FFFF;
    localparam logic [31:0] tim_base_addr     = 32'h2000_0000;
    localparam logic [31:0] tim_mask_addr     = 32'h0000_FFFF;
    localparam logic [31:0] spi_base_addr     = 32'h3000_0000;
    localparam logic [31:0] spi_mask_addr     = 32'h0000_FFFF;
    localparam logic [31:0] clint_base_addr   = 32'h4000_0000;
    localparam logic [31:0] clint_mask_addr   = 32'h000F_FFFF;
    localparam logic [31:0] uart_rx_base_addr = 32'h5000_0000;
    localparam logic [31:0] uart_rx_mask_addr = 32'h0000_0003;
    localparam logic [31:0] uart_tx_base_addr = 32'h5000_0004;
    localparam logic [31:0] uart_tx_mask_addr = 32'h0000_0003;

    // Packed arrays: element [k] matches slv_idx_e value k (rightmost is rom).
    localparam logic [NUM_SLV_C-1:0][31:0] slv_base_c = {
        uart_tx_base_addr, uart_rx_base_addr, clint_base_addr, spi_base_addr,
        tim_base_addr, ram_base_addr, rom_base_addr
    };
    localparam logic [NUM_SLV_C-1:0][31:0] slv_mask_c = {
        uart_tx_mask_addr, uart_rx_mask_addr, clint_mask_addr, spi_mask_addr,
        tim_mask_addr, ram_mask_addr, rom_mask_addr
    };

endpackage

// File: rtl/mem_decode.sv
// Combinational address decoder: reports the lowest-index matching slave
// and the address offset relative to that slave's base.
module mem_decode
    import mem_router_pkg::*;
#(
    parameter int NUM_SLV = NUM_SLV_C,
    parameter int IW      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
    parameter logic [NUM_SLV-1:0][31:0] SLV_BASE = slv_base_c,
    parameter logic [NUM_SLV-1:0][31:0] SLV_MASK = slv_mask_c
) (
    input  logic [31:0]   addr,
    output logic          hit,
    output logic [IW-1:0] idx,
    output logic [31:0]   offset
);

    logic [NUM_SLV-1:0] match;

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_match
        assign match[gi] = ((addr & ~SLV_MASK[gi]) == SLV_BASE[gi]);
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        offset = '0;
        for (int k = NUM_SLV - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit    = 1'b1;
                idx    = IW'(k);
                offset = addr - SLV_BASE[k];
            end
        end
    end

endmodule

// File: rtl/mem_router.sv
// Single-outstanding memory router: decodes, issues, tracks the response
// from the selected slave, and produces miss/timeout errors.
module mem_router
    import mem_router_pkg::*;
#(
    parameter int NUM_SLV = NUM_SLV_C,
    parameter int TIMEOUT = router_timeout,
    parameter logic [NUM_SLV-1:0][31:0] SLV_BASE = slv_base_c,
    parameter logic [NUM_SLV-1:0][31:0] SLV_MASK = slv_mask_c
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  m_in,
    output mem_out_type m_out,
    output mem_in_type  s_in  [NUM_SLV],
    input  mem_out_type s_out [NUM_SLV],
    output logic        busy,
    output logic        timeout_evt,
    output logic        overflow
);

    localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    router_state_t state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [TW-1:0] timer_q, timer_d;
    mem_in_type    buf_q, buf_d;
    logic          buf_valid_q, buf_valid_d;
    logic          overflow_q, overflow_d;

    mem_in_type    src;
    mem_in_type    issue_req;
    logic          dec_hit;
    logic [IW-1:0] dec_idx;
    logic [31:0]   dec_offset;

    assign src = buf_valid_q ? buf_q : m_in;

    mem_decode #(
        .NUM_SLV  (NUM_SLV),
        .IW       (IW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr   (src.mem_addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_offset)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        overflow_d  = overflow_q;
        m_out       = init_mem_out;
        timeout_evt = 1'b0;
        issue_req   = src;
        issue_req.mem_addr = dec_offset;
        for (int k = 0; k < NUM_SLV; k++) begin
            s_in[k] = init_mem_in;
        end

        case (state_q)
            IDLE: begin
                if (src.mem_valid) begin
                    if (dec_hit) begin
                        s_in[dec_idx] = issue_req;
                        sel_d         = dec_idx;
                        timer_d       = '0;
                        state_d       = BUSY;
                    end else begin
                        state_d = ERR;
                    end
                end
                // Draining the buffer frees it for a simultaneous new request.
                if (buf_valid_q) begin
                    buf_valid_d = m_in.mem_valid;
                    if (m_in.mem_valid) begin
                        buf_d = m_in;
                    end
                end
            end
            BUSY: begin
                if (s_out[sel_q].mem_ready) begin
                    m_out   = s_out[sel_q];
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_evt = 1'b1;
                    state_d     = ERR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                m_out.mem_ready = 1'b1;
                m_out.mem_error = 1'b1;
                m_out.mem_rdata = '0;
                state_d         = IDLE;
            end
        endcase

        if (state_q != IDLE && m_in.mem_valid) begin
            if (!buf_valid_q) begin
                buf_d       = m_in;
                buf_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        // Keep every output quiet for as long as reset is held.
        if (!reset) begin
            m_out       = init_mem_out;
            timeout_evt = 1'b0;
            for (int k = 0; k < NUM_SLV; k++) begin
                s_in[k] = init_mem_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            timer_q     <= '0;
            buf_q       <= init_mem_in;
            buf_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mem_router.sv
// Directed testbench for mem_router with a short timeout (TIMEOUT=16).
module tb_mem_router;
    import mem_router_pkg::*;

    localparam int NS = 7;

    logic        clock;
    logic        reset;
    mem_in_type  m_in;
    mem_out_type m_out;
    mem_in_type  s_in  [NS];
    mem_out_type s_out [NS];
    logic        busy;
    logic        timeout_evt;
    logic        overflow;

    int vectors;
    int miscompares;

    mem_router #(
        .NUM_SLV (NS),
        .TIMEOUT (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .m_in        (m_in),
        .m_out       (m_out),
        .s_in        (s_in),
        .s_out       (s_out),
        .busy        (busy),
        .timeout_evt (timeout_evt),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int count_valid();
        int n = 0;
        for (int k = 0; k < NS; k++) n += int'(s_in[k].mem_valid);
        return n;
    endfunction

    task automatic send(input logic [31:0] addr);
        m_in           = init_mem_in;
        m_in.mem_valid = 1'b1;
        m_in.mem_addr  = addr;
    endtask

    task automatic clear_inputs();
        m_in = init_mem_in;
        for (int k = 0; k < NS; k++) s_out[k] = init_mem_out;
    endtask

    task automatic set_ready(input int k, input logic [31:0] rdata);
        s_out[k]           = init_mem_out;
        s_out[k].mem_ready = 1'b1;
        s_out[k].mem_rdata = rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #3 reset = 1'b0;
        send(32'h1000_0040);
        #1;
        vectors++;
        if (count_valid() !== 0) begin
            miscompares++;
            $display("FAIL reset_s_in: got %0d valid, expected 0", count_valid());
        end
        vectors++;
        if (m_out !== init_mem_out) begin
            miscompares++;
            $display("FAIL reset_m_out: got %h expected %h", m_out, init_mem_out);
        end
        vectors++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy=%b overflow=%b expected 0 0", busy, overflow);
        end
        repeat (2) @(posedge clock);
        clear_inputs();
        #5 reset = 1'b1;
        tick();
        $display("reset: done");
    endtask

    task automatic test_hit();
        send(32'h1000_0010);
        #1;
        vectors++;
        if (s_in[SLV_RAM].mem_valid !== 1'b1 || s_in[SLV_RAM].mem_addr !== 32'h10 || count_valid() !== 1) begin
            miscompares++;
            $display("FAIL hit_issue: got valid=%b addr=%h n=%0d expected 1 00000010 1",
                     s_in[SLV_RAM].mem_valid, s_in[SLV_RAM].mem_addr, count_valid());
        end
        tick();
        m_in = init_mem_in;
        repeat (2) begin
            #1;
            vectors++;
            if (busy !== 1'b1 || m_out.mem_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hit_wait: got busy=%b ready=%b expected 1 0", busy, m_out.mem_ready);
            end
            tick();
        end
        set_ready(SLV_RAM, 32'hDEAD_BEEF);
        #1;
        vectors++;
        if (m_out.mem_ready !== 1'b1 || m_out.mem_error !== 1'b0 || m_out.mem_rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL hit_resp: got %h expected ready=1 error=0 rdata=deadbeef", m_out);
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (busy !== 1'b0 || m_out !== init_mem_out) begin
            miscompares++;
            $display("FAIL hit_idle: got busy=%b m_out=%h expected 0 init", busy, m_out);
        end
        $display("hit: ram read addr=10000010 completed");
    endtask

    task automatic test_miss();
        send(32'hF000_0000);
        #1;
        vectors++;
        if (count_valid() !== 0 || m_out.mem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL miss_issue: got n=%0d ready=%b expected 0 0", count_valid(), m_out.mem_ready);
        end
        tick();
        m_in = init_mem_in;
        #1;
        vectors++;
        if (busy !== 1'b1 || m_out.mem_ready !== 1'b1 || m_out.mem_error !== 1'b1 || m_out.mem_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL miss_resp: got busy=%b m_out=%h expected busy=1 ready=1 error=1 rdata=0", busy, m_out);
        end
        tick();
        #1;
        vectors++;
        if (busy !== 1'b0 || m_out !== init_mem_out) begin
            miscompares++;
            $display("FAIL miss_idle: got busy=%b m_out=%h expected 0 init", busy, m_out);
        end
        $display("miss: addr=f0000000 error response");
    endtask

    task automatic test_timeout();
        send(32'h3000_0008);
        tick();
        m_in = init_mem_in;
        // Cycle c counts from the first BUSY cycle, so the timer equals c.
        for (int c = 0; c < 15; c++) begin
            #1;
            vectors++;
            if (timeout_evt !== 1'b0 || m_out.mem_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL to_early c=%0d: got evt=%b ready=%b expected 0 0", c, timeout_evt, m_out.mem_ready);
            end
            tick();
        end
        #1;
        vectors++;
        if (timeout_evt !== 1'b1 || busy !== 1'b1 || m_out.mem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL to_evt: got evt=%b busy=%b ready=%b expected 1 1 0", timeout_evt, busy, m_out.mem_ready);
        end
        tick();
        #1;
        vectors++;
        if (m_out.mem_ready !== 1'b1 || m_out.mem_error !== 1'b1 || m_out.mem_rdata !== 32'h0 || timeout_evt !== 1'b0) begin
            miscompares++;
            $display("FAIL to_resp: got m_out=%h evt=%b expected ready=1 error=1 rdata=0 evt=0", m_out, timeout_evt);
        end
        repeat (4) tick();
        set_ready(SLV_SPI, 32'h0000_1234);
        #1;
        vectors++;
        if (m_out !== init_mem_out || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL to_late: got m_out=%h busy=%b expected init 0", m_out, busy);
        end
        tick();
        clear_inputs();
        $display("timeout: spi request timed out, late ready discarded");
    endtask

    task automatic test_stray_ready();
        send(32'h2000_0000);
        tick();
        m_in = init_mem_in;
        set_ready(SLV_UART_RX, 32'h0000_0055);
        #1;
        vectors++;
        if (m_out.mem_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stray: got ready=%b busy=%b expected 0 1", m_out.mem_ready, busy);
        end
        tick();
        clear_inputs();
        set_ready(SLV_TIM, 32'hCAFE_0001);
        #1;
        vectors++;
        if (m_out.mem_ready !== 1'b1 || m_out.mem_rdata !== 32'hCAFE_0001) begin
            miscompares++;
            $display("FAIL stray_resp: got %h expected ready=1 rdata=cafe0001", m_out);
        end
        tick();
        clear_inputs();
        $display("stray: uart_rx ready ignored while busy on tim");
    endtask

    task automatic test_ready_at_timeout();
        send(32'h2000_0004);
        tick();
        m_in = init_mem_in;
        repeat (15) tick();
        set_ready(SLV_TIM, 32'h0BAD_F00D);
        #1;
        vectors++;
        if (m_out.mem_ready !== 1'b1 || m_out.mem_error !== 1'b0 || m_out.mem_rdata !== 32'h0BAD_F00D || timeout_evt !== 1'b0) begin
            miscompares++;
            $display("FAIL simul: got m_out=%h evt=%b expected ready=1 error=0 rdata=0badf00d evt=0", m_out, timeout_evt);
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (busy !== 1'b0 || m_out !== init_mem_out) begin
            miscompares++;
            $display("FAIL simul_idle: got busy=%b m_out=%h expected 0 init", busy, m_out);
        end
        $display("simul: ready at last timer value wins");
    endtask

    task automatic test_back_to_back();
        send(32'h1000_0004);
        #1;
        vectors++;
        if (s_in[SLV_RAM].mem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ram_issue: got %b expected 1", s_in[SLV_RAM].mem_valid);
        end
        tick();
        send(32'h0000_0100);
        #1;
        vectors++;
        if (s_in[SLV_ROM].mem_valid !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_capture: got rom_valid=%b overflow=%b expected 0 0", s_in[SLV_ROM].mem_valid, overflow);
        end
        tick();
        send(32'h2000_0020);
        tick();
        m_in = init_mem_in;
        #1;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_overflow: got %b expected 1", overflow);
        end
        tick();
        set_ready(SLV_RAM, 32'h1111_2222);
        #1;
        vectors++;
        if (m_out.mem_ready !== 1'b1 || m_out.mem_rdata !== 32'h1111_2222 || s_in[SLV_ROM].mem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ram_resp: got m_out=%h rom_valid=%b expected ready=1 rdata=11112222 0", m_out, s_in[SLV_ROM].mem_valid);
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (s_in[SLV_ROM].mem_valid !== 1'b1 || s_in[SLV_ROM].mem_addr !== 32'h100 || busy !== 1'b0 || count_valid() !== 1) begin
            miscompares++;
            $display("FAIL b2b_rom_issue: got valid=%b addr=%h busy=%b n=%0d expected 1 00000100 0 1",
                     s_in[SLV_ROM].mem_valid, s_in[SLV_ROM].mem_addr, busy, count_valid());
        end
        tick();
        set_ready(SLV_ROM, 32'h3333_4444);
        #1;
        vectors++;
        if (m_out.mem_ready !== 1'b1 || m_out.mem_rdata !== 32'h3333_4444) begin
            miscompares++;
            $display("FAIL b2b_rom_resp: got %h expected ready=1 rdata=33334444", m_out);
        end
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (busy !== 1'b0 || overflow !== 1'b1 || count_valid() !== 0) begin
            miscompares++;
            $display("FAIL b2b_end: got busy=%b overflow=%b n=%0d expected 0 1 0", busy, overflow, count_valid());
        end
        $display("back_to_back: ram then buffered rom, third request dropped");
    endtask

    task automatic test_reset_mid();
        send(32'h1000_0000);
        tick();
        send(32'h0000_0200);
        tick();
        m_in = init_mem_in;
        #2 reset = 1'b0;
        set_ready(SLV_RAM, 32'h5555_6666);
        #1;
        vectors++;
        if (busy !== 1'b0 || overflow !== 1'b0 || count_valid() !== 0 || m_out !== init_mem_out) begin
            miscompares++;
            $display("FAIL rst_mid: got busy=%b overflow=%b n=%0d m_out=%h expected 0 0 0 init",
                     busy, overflow, count_valid(), m_out);
        end
        tick();
        clear_inputs();
        #2 reset = 1'b1;
        tick();
        #1;
        vectors++;
        if (count_valid() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_buf_cleared: got n=%0d busy=%b expected 0 0", count_valid(), busy);
        end
        tick();
        send(32'h1000_0080);
        #1;
        vectors++;
        if (s_in[SLV_RAM].mem_valid !== 1'b1 || s_in[SLV_RAM].mem_addr !== 32'h80) begin
            miscompares++;
            $display("FAIL rst_after_issue: got valid=%b addr=%h expected 1 00000080",
                     s_in[SLV_RAM].mem_valid, s_in[SLV_RAM].mem_addr);
        end
        tick();
        m_in = init_mem_in;
        set_ready(SLV_RAM, 32'h7777_8888);
        #1;
        vectors++;
        if (m_out.mem_ready !== 1'b1 || m_out.mem_error !== 1'b0 || m_out.mem_rdata !== 32'h7777_8888) begin
            miscompares++;
            $display("FAIL rst_after_resp: got %h expected ready=1 error=0 rdata=77778888", m_out);
        end
        tick();
        clear_inputs();
        $display("reset_mid: aborted in flight, ram request completed after release");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_hit();
        test_miss();
        test_timeout();
        test_stray_ready();
        test_ready_at_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
